// File: rtl/uvmt_rvfi_csr_shadow.sv
// uvmt_rvfi_csr_shadow
// Shadow model of a set of CSR channels driven from RVFI retirement data.
// Each retirement compares the reported pre-instruction read value against the
// shadow on bits that are both read and already known, then re-learns the
// shadow from the retirement so the model tracks the DUT even after an error.
// Error state (sticky flag, saturating count, first-error index) is reported
// separately and can be cleared without disturbing the shadow.

module uvmt_rvfi_csr_shadow #(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned NUM_CSR = 4,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W   = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rvfi_valid_i,
  input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_rmask_i,
  input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_wmask_i,
  input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_rdata_i,
  input  logic [NUM_CSR*XLEN-1:0]   rvfi_csr_wdata_i,
  input  logic                      clear_i,
  output logic [NUM_CSR*XLEN-1:0]   shadow_o,
  output logic [NUM_CSR*XLEN-1:0]   known_o,
  output logic                      mismatch_o,
  output logic                      err_sticky_o,
  output logic [CNT_W-1:0]          err_cnt_o,
  output logic [IDX_W-1:0]          err_idx_o
);

  localparam int unsigned BUS_W = NUM_CSR * XLEN;

  // Shadow / known state
  logic [BUS_W-1:0]   r_shadow;
  logic [BUS_W-1:0]   r_known;

  // Error reporting state
  logic               r_mismatch;
  logic               r_sticky;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;

  // Combinational terms
  logic [BUS_W-1:0]   w_hit;
  logic [NUM_CSR-1:0] w_mis;
  logic               w_ev;
  logic [IDX_W-1:0]   w_first_idx;
  logic [BUS_W-1:0]   w_shadow_nxt;
  logic [BUS_W-1:0]   w_known_nxt;
  logic               w_sticky_base;
  logic [CNT_W-1:0]   w_cnt_base;
  logic [IDX_W-1:0]   w_idx_base;
  logic               w_sticky_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;

  // Bits that are read, already known and differ from the pre-update shadow
  assign w_hit = rvfi_csr_rmask_i & r_known & (rvfi_csr_rdata_i ^ r_shadow);

  // Per-channel mismatch reduction, qualified by a valid retirement
  always_comb begin
    w_mis = '0;
    for (int unsigned i = 0; i < NUM_CSR; i++) begin
      w_mis[i] = rvfi_valid_i & (|w_hit[i*XLEN +: XLEN]);
    end
  end

  assign w_ev = |w_mis;

  // Lowest mismatching channel: scan downward so the lowest index wins last
  always_comb begin
    w_first_idx = '0;
    for (int unsigned i = NUM_CSR; i > 0; i--) begin
      if (w_mis[i-1]) begin
        w_first_idx = IDX_W'(i - 1);
      end
    end
  end

  // Per-bit learning: written bits take wdata, read-only bits take rdata
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_known_nxt  = r_known;
    if (rvfi_valid_i) begin
      w_shadow_nxt = (rvfi_csr_wmask_i & rvfi_csr_wdata_i)
                   | (~rvfi_csr_wmask_i & rvfi_csr_rmask_i & rvfi_csr_rdata_i)
                   | (~rvfi_csr_wmask_i & ~rvfi_csr_rmask_i & r_shadow);
      w_known_nxt  = r_known | rvfi_csr_rmask_i | rvfi_csr_wmask_i;
    end
  end

  // Error next-state: a same-cycle clear is applied before the event
  always_comb begin
    w_sticky_base = clear_i ? 1'b0 : r_sticky;
    w_cnt_base    = clear_i ? '0   : r_cnt;
    w_idx_base    = clear_i ? '0   : r_idx;
    w_sticky_nxt  = w_sticky_base;
    w_cnt_nxt     = w_cnt_base;
    w_idx_nxt     = w_idx_base;
    if (w_ev) begin
      w_sticky_nxt = 1'b1;
      w_cnt_nxt    = (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + 1'b1;
      w_idx_nxt    = w_sticky_base ? w_idx_base : w_first_idx;
    end
  end

  // Shadow and known registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= '0;
      r_known  <= '0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_known  <= w_known_nxt;
    end
  end

  // Mismatch pulse and error-state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mismatch <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= '0;
      r_idx      <= '0;
    end else begin
      r_mismatch <= w_ev;
      r_sticky   <= w_sticky_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
    end
  end

  assign shadow_o     = r_shadow;
  assign known_o      = r_known;
  assign mismatch_o   = r_mismatch;
  assign err_sticky_o = r_sticky;
  assign err_cnt_o    = r_cnt;
  assign err_idx_o    = r_idx;

endmodule

// File: tb/tb_uvmt_rvfi_csr_shadow.sv
// Directed bench for uvmt_rvfi_csr_shadow (XLEN=32, NUM_CSR=4, CNT_W=2).
module tb_uvmt_rvfi_csr_shadow;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic [127:0] rmask;
  logic [127:0] wmask;
  logic [127:0] rdata;
  logic [127:0] wdata;
  logic         clear;
  logic [127:0] shadow;
  logic [127:0] known;
  logic         mismatch;
  logic         sticky;
  logic [1:0]   cnt;
  logic [1:0]   idx;

  int checks = 0;
  int errors = 0;

  uvmt_rvfi_csr_shadow #(
    .XLEN    (32),
    .NUM_CSR (4),
    .CNT_W   (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .rvfi_valid_i     (valid),
    .rvfi_csr_rmask_i (rmask),
    .rvfi_csr_wmask_i (wmask),
    .rvfi_csr_rdata_i (rdata),
    .rvfi_csr_wdata_i (wdata),
    .clear_i          (clear),
    .shadow_o         (shadow),
    .known_o          (known),
    .mismatch_o       (mismatch),
    .err_sticky_o     (sticky),
    .err_cnt_o        (cnt),
    .err_idx_o        (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid = 1'b0;
    clear = 1'b0;
    rmask = '0;
    wmask = '0;
    rdata = '0;
    wdata = '0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] rm, input logic [31:0] wm,
                        input logic [31:0] rd, input logic [31:0] wd);
    rmask[ch*32 +: 32] = rm;
    wmask[ch*32 +: 32] = wm;
    rdata[ch*32 +: 32] = rd;
    wdata[ch*32 +: 32] = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string tag, input logic m, input logic s,
                         input logic [1:0] c, input logic [1:0] i);
    chk({tag, "_mismatch"}, 128'(mismatch), 128'(m));
    chk({tag, "_sticky"},   128'(sticky),   128'(s));
    chk({tag, "_cnt"},      128'(cnt),      128'(c));
    chk({tag, "_idx"},      128'(idx),      128'(i));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk("rst_shadow", shadow, '0);
    chk("rst_known", known, '0);
    chk_err("rst", 1'b0, 1'b0, 2'd0, 2'd0);

    // Write ch1 with 0x1800
    rst_n = 1'b1;
    valid = 1'b1;
    set_ch(1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_1800);
    tick();
    chk("wr_shadow", shadow, {32'h0, 32'h0, 32'h0000_1800, 32'h0});
    chk("wr_known", known, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0});
    chk_err("wr", 1'b0, 1'b0, 2'd0, 2'd0);

    // Read ch1 with a differing value
    idle();
    valid = 1'b1;
    set_ch(1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0800, 32'h0);
    tick();
    chk_err("rd_mis", 1'b1, 1'b1, 2'd1, 2'd1);
    chk("rd_mis_shadow", shadow, {32'h0, 32'h0, 32'h0000_0800, 32'h0});

    // Invalid retirement with conflicting data must change nothing
    idle();
    set_ch(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0);
    tick();
    chk_err("novalid", 1'b0, 1'b1, 2'd1, 2'd1);
    chk("novalid_shadow", shadow, {32'h0, 32'h0, 32'h0000_0800, 32'h0});
    chk("novalid_known", known, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0});

    // ch0: learn only bits [7:0] = 0x5A
    idle();
    valid = 1'b1;
    set_ch(0, 32'h0, 32'h0000_00FF, 32'h0, 32'h0000_005A);
    tick();
    chk("part_known", known, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_00FF});
    // Full read: unknown upper bits must not mismatch
    idle();
    valid = 1'b1;
    set_ch(0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FF5A, 32'h0);
    tick();
    chk_err("part_rd", 1'b0, 1'b1, 2'd1, 2'd1);
    chk("part_rd_known", known, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    chk("part_rd_shadow", shadow, {32'h0, 32'h0, 32'h0000_0800, 32'hFFFF_FF5A});

    // Clear alone
    idle();
    clear = 1'b1;
    tick();
    chk_err("clr1", 1'b0, 1'b0, 2'd0, 2'd0);

    // Learn ch2=0x22, ch3=0x33
    idle();
    valid = 1'b1;
    set_ch(2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h22);
    set_ch(3, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h33);
    tick();
    chk_err("learn23", 1'b0, 1'b0, 2'd0, 2'd0);

    // Five consecutive mismatches, first on ch2, saturating counter
    idle(); valid = 1'b1; set_ch(2, 32'hFFFF_FFFF, 32'h0, 32'h99, 32'h0);
    tick(); chk_err("sat1", 1'b1, 1'b1, 2'd1, 2'd2);
    idle(); valid = 1'b1; set_ch(3, 32'hFFFF_FFFF, 32'h0, 32'h44, 32'h0);
    tick(); chk_err("sat2", 1'b1, 1'b1, 2'd2, 2'd2);
    idle(); valid = 1'b1; set_ch(2, 32'hFFFF_FFFF, 32'h0, 32'h22, 32'h0);
    tick(); chk_err("sat3", 1'b1, 1'b1, 2'd3, 2'd2);
    idle(); valid = 1'b1; set_ch(3, 32'hFFFF_FFFF, 32'h0, 32'h33, 32'h0);
    tick(); chk_err("sat4", 1'b1, 1'b1, 2'd3, 2'd2);
    idle(); valid = 1'b1; set_ch(2, 32'hFFFF_FFFF, 32'h0, 32'h99, 32'h0);
    tick(); chk_err("sat5", 1'b1, 1'b1, 2'd3, 2'd2);

    // Clear with simultaneous ch0 and ch3 mismatch: event follows the clear
    idle();
    valid = 1'b1;
    clear = 1'b1;
    set_ch(0, 32'h0000_00FF, 32'h0, 32'h0, 32'h0);
    set_ch(3, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    tick();
    chk_err("clr_ev", 1'b1, 1'b1, 2'd1, 2'd0);

    // Clear alone: error outputs drop, shadow untouched
    idle();
    clear = 1'b1;
    tick();
    chk_err("clr2", 1'b0, 1'b0, 2'd0, 2'd0);
    chk("clr2_shadow", shadow, {32'h0, 32'h99, 32'h0000_0800, 32'hFFFF_FF00});
    chk("clr2_known", known, '1);

    // Simultaneous ch1 and ch3 mismatch: lowest index recorded
    idle();
    valid = 1'b1;
    set_ch(1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    set_ch(3, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0);
    tick();
    chk_err("multi", 1'b1, 1'b1, 2'd1, 2'd1);
    // Later ch0 error must not overwrite the index
    idle();
    valid = 1'b1;
    set_ch(0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    tick();
    chk_err("keep_idx", 1'b1, 1'b1, 2'd2, 2'd1);

    // Asynchronous reset mid-stream
    idle();
    valid = 1'b1;
    set_ch(2, 32'hFFFF_FFFF, 32'h0, 32'h5, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_shadow", shadow, '0);
    chk("arst_known", known, '0);
    chk_err("arst", 1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    idle();
    valid = 1'b1;
    rmask = '1;
    rdata = {4{32'hDEAD_BEEF}};
    tick();
    chk_err("post_rst", 1'b0, 1'b0, 2'd0, 2'd0);
    chk("post_rst_shadow", shadow, {4{32'hDEAD_BEEF}});
    chk("post_rst_known", known, '1);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uvmt_rvfi_csr_shadow.md
UVMT_RVFI_CSR_SHADOW -- requirements
Module: uvmt_rvfi_csr_shadow

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, CSR data width in bits.
REQ-002 The block SHALL have parameter NUM_CSR, default 4, number of tracked CSR channels (1..64).
REQ-003 The block SHALL have parameter CNT_W, default 8, error counter width.
REQ-004 The block SHALL define IDX_W = max(1, clog2(NUM_CSR)) for index outputs.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 rvfi_valid_i  input  1  one instruction retires this cycle.
REQ-008 rvfi_csr_rmask_i  input  NUM_CSR*XLEN  per-CSR read mask; channel i occupies bits [i*XLEN +: XLEN] (same packing for all per-CSR buses).
REQ-009 rvfi_csr_wmask_i  input  NUM_CSR*XLEN  per-CSR write mask.
REQ-010 rvfi_csr_rdata_i  input  NUM_CSR*XLEN  per-CSR pre-instruction read value.
REQ-011 rvfi_csr_wdata_i  input  NUM_CSR*XLEN  per-CSR post-instruction written value.
REQ-012 clear_i  input  1  synchronous clear of error state (not of shadow state).
REQ-013 shadow_o  output  NUM_CSR*XLEN  tracked CSR values.
REQ-014 known_o  output  NUM_CSR*XLEN  per-bit "shadow value is known" flags.
REQ-015 mismatch_o  output  1  registered one-cycle pulse: previous retirement mismatched.
REQ-016 err_sticky_o  output  1  at least one mismatch since reset/clear.
REQ-017 err_cnt_o  output  CNT_W  count of mismatching retirements, saturating.
REQ-018 err_idx_o  output  IDX_W  lowest mismatching channel index of the first error since reset/clear.

Function
REQ-019 Per channel i, on a cycle with rvfi_valid_i=1, mis[i] SHALL = |(rmask & known & (rdata ^ shadow)), using pre-update shadow/known.
REQ-020 Any mis[i]=1 SHALL make the retirement a mismatch event (ev=1); ev SHALL be 0 when rvfi_valid_i=0.
REQ-021 On rvfi_valid_i=1, per bit: wmask=1 -> shadow<=wdata; wmask=0 and rmask=1 -> shadow<=rdata; otherwise unchanged.
REQ-022 On rvfi_valid_i=1, known SHALL become known | rmask | wmask; known bits never clear except by reset.
REQ-023 Shadow learning per REQ-021 SHALL occur even when ev=1 (resynchronise to DUT).
REQ-024 With rvfi_valid_i=0, shadow and known SHALL hold regardless of mask/data inputs.
REQ-025 mismatch_o SHALL equal ev of the previous cycle (latency 1), 0 otherwise.
REQ-026 On ev=1: err_sticky_o<=1; err_cnt_o<=err_cnt_o+1 unless all-ones (saturate, no wrap).
REQ-027 err_idx_o SHALL load the lowest i with mis[i]=1 only when ev=1 and err_sticky_o=0 (or clear_i=1 same cycle); later errors SHALL not overwrite it.
REQ-028 clear_i=1 SHALL zero err_sticky_o, err_cnt_o, err_idx_o; if ev=1 in the same cycle, clear applies first then the event: sticky=1, cnt=1, idx=that event's index.
REQ-029 clear_i SHALL not affect shadow_o, known_o or mismatch_o.
REQ-030 Channels SHALL be fully independent; NUM_CSR=1 SHALL work with err_idx_o fixed 0.

Reset
REQ-031 While rst_ni=0, all outputs SHALL be 0 (shadow, known, mismatch, sticky, count, index), asynchronously.
REQ-032 Reset asserted mid-operation SHALL discard all learned state; first retirement after release SHALL not mismatch (known=0).

Verification
REQ-033 XLEN=32,NUM_CSR=4: valid, ch1 wmask=FFFFFFFF wdata=0000_1800 -> next cycle shadow ch1=0000_1800, known ch1=FFFFFFFF, mismatch_o=0.
REQ-034 Then valid, ch1 rmask=FFFFFFFF rdata=0000_0800 -> mismatch_o=1 one cycle later, sticky=1, cnt=1, idx=1, shadow ch1=0000_0800.
REQ-035 Known only bits [7:0] on ch0 (shadow 0x5A); read rmask=FFFFFFFF rdata=0xFFFF_FF5A -> no mismatch, known ch0 becomes FFFFFFFF.
REQ-036 CNT_W=2: five consecutive mismatching retirements -> cnt 1,2,3,3,3; idx stays at first value; second error on ch3 after first on ch2 leaves idx=2.
REQ-037 clear_i and a ch0 mismatch same cycle while cnt=3 -> cnt=1, sticky=1, idx=0; clear_i alone -> all error outputs 0, shadow unchanged.
REQ-038 rst_ni pulsed low mid-stream -> all outputs 0 immediately; post-release read of any value -> no mismatch.
